// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter: baud default, frame layout, FSM encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // 50 MHz core clock / 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  // Characters per response frame (address, command, value).
  localparam int BYTES_PER_FRAME = 3;

  // Data bits per 8N1 character.
  localparam int BITS_PER_CHAR = 8;

  // Frame field positions, most-significant byte goes out first.
  localparam int ADDR_MSB = 23;
  localparam int CMD_MSB  = 15;
  localparam int VAL_MSB  = 7;

  // Character serialiser states.
  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_e;

  // Frame sequencer states; DONE is the single-cycle completion state.
  typedef enum logic [1:0] {
    FRAME_IDLE,
    FRAME_SEND,
    FRAME_DONE
  } frame_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-character 8N1 serialiser (start bit, 8 data bits LSB first, stop bit) with its own baud counter.
// Latency: tx reflects a character one cycle after byte_valid is taken; a character lasts 10*CLKS_PER_BIT cycles.
// Backpressure: byte_valid is taken only when idle or in the last stop-bit cycle (byte_done), giving gapless chaining.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_dat,
  output logic       byte_done,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic        tx_d;
  logic        tick;

  assign tick = (cnt_q == CNT_LAST);

  // State, baud counter, bit index, character and line register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx      <= tx_d;
    end
  end

  // Next-state, counter sequencing and the line level for the current bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    byte_done = 1'b0;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (byte_valid) begin
          byte_d  = byte_dat;
          state_d = START_BIT;
        end
      end

      START_BIT: begin
        tx_d = 1'b0;
        if (tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA_BITS: begin
        tx_d = byte_q[bit_q];
        if (tick) begin
          cnt_d = '0;
          if (bit_q == 3'(BITS_PER_CHAR - 1)) begin
            state_d = STOP_BIT;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP_BIT: begin
        tx_d = 1'b1;
        if (tick) begin
          cnt_d     = '0;
          byte_done = 1'b1;
          // A character offered in the last stop cycle starts with no idle gap.
          if (byte_valid) begin
            byte_d  = byte_dat;
            state_d = START_BIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Serialises a multi-byte response frame as back-to-back 8N1 characters, MSB byte first, with wait/done handshake.
// Latency: tx low and wait high one cycle after acceptance; done pulses 30*CLKS_PER_BIT+1 cycles after acceptance.
// Backpressure: start_transmitter is only sampled in idle; wait_transmitter high means busy, requests are ignored.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int BYTES_PER_FRAME = uart_pkg::BYTES_PER_FRAME
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_transmitter,
  input  logic [8*BYTES_PER_FRAME-1:0] data_transmitter,
  output logic                         tx,
  output logic                         wait_transmitter,
  output logic                         done_transmittion
);

  localparam int FRAME_W = 8 * BYTES_PER_FRAME;
  localparam int IDXW    = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(BYTES_PER_FRAME - 1);

  frame_state_e       fstate_q, fstate_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               byte_valid;
  logic [7:0]         byte_dat;
  logic               byte_done;
  logic               wait_d;
  logic               done_d;

  // Sequencer state, remaining-bytes shift register, byte index and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate_q          <= FRAME_IDLE;
      shift_q           <= '0;
      idx_q             <= '0;
      wait_transmitter  <= 1'b0;
      done_transmittion <= 1'b0;
    end else begin
      fstate_q          <= fstate_d;
      shift_q           <= shift_d;
      idx_q             <= idx_d;
      wait_transmitter  <= wait_d;
      done_transmittion <= done_d;
    end
  end

  // Byte sequencing: first byte comes straight from the input on acceptance, the rest from the shift register.
  always_comb begin
    fstate_d   = fstate_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    byte_valid = 1'b0;
    byte_dat   = shift_q[FRAME_W-1 -: 8];
    wait_d     = (fstate_q == FRAME_SEND);
    done_d     = (fstate_q == FRAME_DONE);

    case (fstate_q)
      FRAME_IDLE: begin
        if (start_transmitter) begin
          byte_valid = 1'b1;
          byte_dat   = data_transmitter[FRAME_W-1 -: 8];
          shift_d    = data_transmitter << 8;
          idx_d      = '0;
          fstate_d   = FRAME_SEND;
        end
      end

      FRAME_SEND: begin
        if (byte_done) begin
          if (idx_q == IDX_LAST) begin
            fstate_d = FRAME_DONE;
          end else begin
            byte_valid = 1'b1;
            shift_d    = shift_q << 8;
            idx_d      = idx_q + 1'b1;
          end
        end
      end

      // Completion cycle: start_transmitter is deliberately ignored here.
      FRAME_DONE: begin
        fstate_d = FRAME_IDLE;
      end

      default: begin
        fstate_d = FRAME_IDLE;
      end
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_dat   (byte_dat),
    .byte_done  (byte_done),
    .tx         (tx)
  );

endmodule
